// File: rtl/nabp_filtered_ram_banked.sv
// nabp_filtered_ram_banked: double-banked filtered projection line RAM with host fill FSM and NUM_RD read ports.
// Define NABP_FRAM_ABORT_EN to add the hs_fill_abort input.
module nabp_filtered_ram_banked #(
    parameter int DATA_WIDTH = 16,
    parameter int S_WIDTH    = 9,
    parameter int LINE_SIZE  = 512,
    parameter int NUM_RD     = 4,
    parameter int FILL_DELAY = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         hs_fill_kick,
`ifdef NABP_FRAM_ABORT_EN
    input  logic                         hs_fill_abort,
`endif
    input  logic [DATA_WIDTH-1:0]        hs_val,
    output logic [S_WIDTH-1:0]           hs_s_val,
    output logic                         hs_fill_done,
    output logic                         bank_pending,
    input  logic                         swap_req,
    output logic                         swap_ack,
    input  logic [NUM_RD*S_WIDTH-1:0]    rd_s_val,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_val
);
    typedef enum logic [1:0] {READY, DELAY, FILL} state_t;
    localparam logic [S_WIDTH-1:0] LAST = S_WIDTH'(LINE_SIZE - 1);
    localparam logic [S_WIDTH-1:0] DLY  = S_WIDTH'(FILL_DELAY);
    state_t state, state_nxt;
    logic [S_WIDTH-1:0] read_itr, write_itr, read_nxt, write_nxt;
    logic active_bank, abort, do_write, last_write, do_swap;
    logic [DATA_WIDTH-1:0] mem [2][LINE_SIZE];
`ifdef NABP_FRAM_ABORT_EN
    assign abort = hs_fill_abort && state != READY;
`else
    assign abort = 1'b0;
`endif
    assign do_write     = state == FILL && !abort;
    assign last_write   = do_write && write_itr == LAST;
    assign do_swap      = state == READY && swap_req && bank_pending;
    assign hs_fill_done = last_write;
    assign hs_s_val     = read_itr;
    always_comb begin
        state_nxt = state;
        read_nxt  = '0;
        write_nxt = '0;
        if (state == DELAY) begin
            read_nxt  = read_itr + 1'b1;
            state_nxt = (read_itr == DLY) ? FILL : DELAY;
        end else if (state == FILL) begin
            read_nxt  = (read_itr == LAST) ? LAST : read_itr + 1'b1;
            write_nxt = write_itr + 1'b1;
            state_nxt = last_write ? READY : FILL;
        end else if (hs_fill_kick && !bank_pending) begin
            state_nxt = DELAY;
        end
        // Leaving a fill for any reason always restarts both iterators.
        if (abort || state_nxt == READY) begin
            state_nxt = READY;
            read_nxt  = '0;
            write_nxt = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= READY;
            read_itr     <= '0;
            write_itr    <= '0;
            active_bank  <= 1'b0;
            bank_pending <= 1'b0;
            swap_ack     <= 1'b0;
            rd_val       <= '0;
        end else begin
            state        <= state_nxt;
            read_itr     <= read_nxt;
            write_itr    <= write_nxt;
            active_bank  <= active_bank ^ do_swap;
            bank_pending <= do_swap ? 1'b0 : (bank_pending | last_write);
            swap_ack     <= do_swap;
            for (int k = 0; k < NUM_RD; k++)
                rd_val[k*DATA_WIDTH +: DATA_WIDTH] <= mem[active_bank][rd_s_val[k*S_WIDTH +: S_WIDTH]];
        end
    end
    // RAM is never reset; only the shadow bank is written.
    always_ff @(posedge clk) begin
        if (reset_n && do_write)
            mem[~active_bank][write_itr] <= hs_val;
    end
endmodule

// File: tb/tb_nabp_filtered_ram_banked.sv
// tb_nabp_filtered_ram_banked: scoreboard bench; stimulus queues expectations, a monitor checks them when due.
module tb_nabp_filtered_ram_banked;
  localparam int DW = 16, SW = 9, LS = 512, NR = 4, FD = 16;
  logic clk = 0, reset_n = 0, hs_fill_kick = 0, swap_req = 0;
`ifdef NABP_FRAM_ABORT_EN
  logic hs_fill_abort = 0;
`endif
  logic [DW-1:0] hs_val = '0;
  logic [SW-1:0] hs_s_val;
  logic hs_fill_done, bank_pending, swap_ack;
  logic [NR*SW-1:0] rd_s_val = '0;
  logic [NR*DW-1:0] rd_val;
  typedef struct { string nm; int sel; int exp; int due; } exp_t;
  exp_t sb[$];
  int cyc = 0, n_cmp = 0, n_fail = 0, active_m = 0;
  int bank_m [2][LS];
  nabp_filtered_ram_banked dut (
    .clk(clk), .reset_n(reset_n), .hs_fill_kick(hs_fill_kick),
`ifdef NABP_FRAM_ABORT_EN
    .hs_fill_abort(hs_fill_abort),
`endif
    .hs_val(hs_val), .hs_s_val(hs_s_val), .hs_fill_done(hs_fill_done),
    .bank_pending(bank_pending), .swap_req(swap_req), .swap_ack(swap_ack),
    .rd_s_val(rd_s_val), .rd_val(rd_val)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int get(input int sel);
    case (sel)
      0: return int'(hs_s_val);
      1: return int'(hs_fill_done);
      2: return int'(bank_pending);
      3: return int'(swap_ack);
      default: return int'($signed(rd_val[(sel-4)*DW +: DW]));
    endcase
  endfunction
  function automatic int fval(input int mode, input int i);
    case (mode)
      0: return i + 100;
      1: return i * 3 - 700;
      2: return 50 - i * 7;
      default: return i ^ 32'h5a5;
    endcase
  endfunction
  always begin
    @(negedge clk);
    #2;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].due == cyc) begin
        n_cmp++;
        if (get(sb[j].sel) !== sb[j].exp) begin
          n_fail++;
          $display("FAIL %s: got %0d, expected %0d at cycle %0d", sb[j].nm, get(sb[j].sel), sb[j].exp, cyc);
        end
        sb.delete(j);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input int sel, input int exp, input int dly);
    sb.push_back('{nm, sel, exp, cyc + dly});
  endtask
  task automatic rd(input int k, input int a);
    rd_s_val[k*SW +: SW] = SW'(a);
    chk($sformatf("rd%0d_addr%0d", k, a), 4 + k, bank_m[active_m][a], 1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_s"}, 0, 0, 0);
    chk({tag, "_done"}, 1, 0, 0);
    chk({tag, "_pend"}, 2, 0, 0);
    chk({tag, "_ack"}, 3, 0, 0);
    for (int k = 0; k < NR; k++) chk($sformatf("%s_rd%0d", tag, k), 4 + k, 0, 0);
  endtask
  task automatic fill(input int mode, input int stop_at, input bit reads);
    int sh;
    int lst[4];
    sh = 1 - active_m;
    lst = '{0, 1, 510, 511};
    hs_fill_kick = 1;
    tick();
    hs_fill_kick = 0;
    for (int d = 0; d <= FD; d++) begin
      chk("delay_s", 0, d, 0);
      tick();
    end
    for (int i = 0; i < LS; i++) begin
      if (i == stop_at) return;
      hs_val = DW'(fval(mode, i));
      bank_m[sh][i] = fval(mode, i);
      chk("fill_done", 1, int'(i == LS - 1), 0);
      if (i < 2 || i > 492) chk("fill_s", 0, (i + FD + 1 > LS - 1) ? LS - 1 : i + FD + 1, 0);
      if (i == LS - 1) chk("pend_early", 2, 0, 0);
      if (reads) for (int k = 0; k < NR; k++) rd(k, lst[(k + i) % 4]);
      tick();
    end
    chk("pend_set", 2, 1, 0);
    chk("done_clr", 1, 0, 0);
    chk("idle_s", 0, 0, 0);
  endtask
  task automatic swap(input bit kick_too, input bit chk_old);
    swap_req = 1;
    hs_fill_kick = kick_too;
    if (chk_old) rd(0, 5);
    tick();
    swap_req = 0;
    hs_fill_kick = 0;
    active_m ^= 1;
    chk("swap_ack", 3, 1, 0);
    chk("swap_pend_clr", 2, 0, 0);
    rd(2, 5);
    tick();
    chk("swap_ack_pulse", 3, 0, 0);
    chk("swap_kick_ignored", 0, 0, 0);
  endtask
  initial begin
    repeat (3) tick();
    if (bank_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pend_direct: got %b", bank_pending);
    end
    if (swap_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ack_direct: got %b", swap_ack);
    end
    if (hs_s_val !== '0) begin
      n_fail++;
      $display("FAIL rst_s_direct: got %0d", hs_s_val);
    end
    chk_reset("rst");
    reset_n = 1;
    tick();
    fill(0, -1, 0);
    hs_fill_kick = 1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("kick_pend_s", 0, 0, 0);
      chk("kick_pend_p", 2, 1, 0);
    end
    hs_fill_kick = 0;
    swap(1, 0);
    swap_req = 1;
    tick();
    swap_req = 0;
    if (swap_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL noswap_ack_direct: got %b", swap_ack);
    end
    chk("noswap_ack", 3, 0, 0);
    rd(1, 7);
    tick();
    chk("noswap_ack2", 3, 0, 0);
    tick();
    fill(1, -1, 1);
    swap(0, 1);
    fill(2, -1, 0);
    swap(0, 1);
    fill(3, 200, 0);
    reset_n = 0;
    tick();
    chk_reset("midrst");
    reset_n = 1;
    active_m = 0;
    rd(0, 5);
    rd(1, 300);
    tick();
    chk("midrst_pend", 2, 0, 0);
    tick();
`ifdef NABP_FRAM_ABORT_EN
    fill(0, 200, 0);
    hs_fill_abort = 1;
    chk("abort_done", 1, 0, 0);
    tick();
    hs_fill_abort = 0;
    chk("abort_s", 0, 0, 0);
    chk("abort_pend", 2, 0, 0);
    swap_req = 1;
    tick();
    swap_req = 0;
    chk("abort_noack", 3, 0, 0);
    chk("abort_s2", 0, 0, 0);
    rd(3, 300);
    tick();
    tick();
`endif
    repeat (3) tick();
    foreach (sb[j]) begin
      n_fail++;
      $display("FAIL %s: never compared, due at cycle %0d", sb[j].nm, sb[j].due);
    end
    if (n_cmp < 12) begin
      n_fail++;
      $display("FAIL too_few_compares: %0d", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/nabp_filtered_ram_banked.md
NABP_FILTERED_RAM_BANKED -- requirements
Module: nabp_filtered_ram_banked

Interface
REQ-001 Parameter DATA_WIDTH, default 16: filtered sample width in bits; samples are signed two's complement.
REQ-002 Parameter S_WIDTH, default 9: width of the projection line address (s) in bits.
REQ-003 Parameter LINE_SIZE, default 512: samples per projection line; LINE_SIZE SHALL be <= 2^S_WIDTH.
REQ-004 Parameter NUM_RD, default 4: number of independent processing read ports.
REQ-005 Parameter FILL_DELAY, default 16: filter pipeline advance in cycles; 1 <= FILL_DELAY < LINE_SIZE.
REQ-006 clk  in  1  clock; all logic SHALL be rising-edge clocked.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 hs_fill_kick  in  1  host request to fill the shadow bank.
REQ-009 hs_val  in  DATA_WIDTH  filtered sample written at the current fill address.
REQ-010 hs_s_val  out  S_WIDTH  host read index into the unfiltered line.
REQ-011 hs_fill_done  out  1  one-cycle pulse when the last sample is written.
REQ-012 bank_pending  out  1  shadow bank holds a complete, not yet swapped line.
REQ-013 swap_req  in  1  request to make the shadow bank active.
REQ-014 swap_ack  out  1  one-cycle pulse confirming a swap.
REQ-015 rd_s_val  in  NUM_RD*S_WIDTH  packed read addresses; port k occupies bits [k*S_WIDTH +: S_WIDTH].
REQ-016 rd_val  out  NUM_RD*DATA_WIDTH  packed signed read data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-017 Two banks of LINE_SIZE words; one is active (read by processing), the other is shadow (written by the host); active_bank register selects which.
REQ-018 Every read port SHALL read the active bank with 1-cycle latency: the address at cycle N returns data from the bank that is active at cycle N, at cycle N+1.
REQ-019 All NUM_RD ports SHALL be readable in the same cycle with no arbitration and no stalls.
REQ-020 Fill FSM states: READY, DELAY, FILL.
REQ-021 READY->DELAY on hs_fill_kick=1 and bank_pending=0; a kick while bank_pending=1 SHALL be ignored.
REQ-022 DELAY: read_itr increments by 1 per cycle from 0; on the cycle read_itr==FILL_DELAY the FSM goes to FILL.
REQ-023 FILL: each cycle hs_val is written to shadow[write_itr] and write_itr increments; read_itr increments and saturates at LINE_SIZE-1.
REQ-024 FILL->READY in the cycle write_itr==LINE_SIZE-1 (that final write happens); hs_fill_done=1 in that cycle only; bank_pending is set to 1 the following cycle.
REQ-025 hs_s_val SHALL equal read_itr at all times; read_itr and write_itr are cleared to 0 in READY.
REQ-026 Swap: swap_req=1 with bank_pending=1 and FSM in READY toggles active_bank and clears bank_pending at the next edge; swap_ack pulses the cycle after the toggle.
REQ-027 swap_req with bank_pending=0 SHALL be ignored; no swap_ack is issued.
REQ-028 swap_req and hs_fill_kick asserted in the same cycle with bank_pending=1: the swap is performed and the kick is ignored; the host must re-assert the kick.

Reset
REQ-029 Reset state: FSM=READY, read_itr=0, write_itr=0, active_bank=0, bank_pending=0, hs_fill_done=0, swap_ack=0, rd_val=0.
REQ-030 Reset during DELAY or FILL abandons the fill; bank_pending stays 0; RAM contents are not cleared and are undefined until written.

Configuration
REQ-031 With NABP_FRAM_ABORT_EN defined: input hs_fill_abort (1 bit); when asserted in DELAY or FILL, the FSM returns to READY at the next edge, both iterators are cleared, no hs_fill_done is issued and bank_pending stays 0.
REQ-032 Without NABP_FRAM_ABORT_EN: the hs_fill_abort port SHALL be absent and fills always run to completion.

Verification
REQ-033 Defaults, kick, hs_val=s+100 -> hs_s_val counts 0..16 in DELAY; 512 writes; hs_fill_done on the 512th write; bank_pending=1 the next cycle.
REQ-034 After REQ-033 fill, swap_req -> active_bank=1, swap_ack the next cycle; port 2 reading address 5 returns 105 one cycle later.
REQ-035 Kick while bank_pending=1 -> FSM stays READY; swap_req with bank_pending=0 -> no swap_ack and active_bank unchanged.
REQ-036 All 4 ports read addresses 0, 1, 510, 511 during a shadow fill -> active-bank data only, unaffected by the writes.
REQ-037 Reset asserted at write_itr=200 -> all registers at reset values and bank_pending=0; with ABORT_EN, abort at write_itr=200 -> READY, no hs_fill_done.
